ddr_sim_sequencer: RTL and testbench
====================================

DDR_SIM_SEQUENCER -- requirements
Module: ddr_sim_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of DDR channels or instances monitored, 1..16.
REQ-002 SHALL have parameter RST_DLY_CYC, default 1: cycles from start until ddr_rstn asserts.
REQ-003 SHALL have parameter RST_LEN_CYC, default 5: cycles ddr_rstn is held low.
REQ-004 SHALL have parameter INIT_TO_CYC, default 200000: timeout, in cycles, for all init_done to go high.
REQ-005 SHALL have parameter RUN_CYC, default 20000: cycles of traffic after init before the verdict.
REQ-006 SHALL have parameter CNT_W, default 32: width of the shared down-counter.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1 bit: a one-cycle pulse that launches a sequence.
REQ-010 SHALL have port init_done, input, NUM_CH bits: per-channel init-complete flags.
REQ-011 SHALL have port err_flag, input, NUM_CH bits: per-channel data-compare error flags.
REQ-012 SHALL have port ddr_rstn, output, 1 bit: active-low reset to the DUT channels.
REQ-013 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until the verdict is reached.
REQ-014 SHALL have port done, output, 1 bit: sticky; high when the sequence has ended.
REQ-015 SHALL have port pass, output, 1 bit: sticky; meaningful only when done is high.
REQ-016 SHALL have port timeout, output, 1 bit: sticky; set when init did not complete in time.
REQ-017 SHALL have port err_ch, output, NUM_CH bits: sticky per-channel error capture.
REQ-018 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-019 SHALL implement the FSM states IDLE=0, RST_DLY=1, RST_ASSERT=2, WAIT_INIT=3, RUN=4, PASS=5, FAIL=6.
REQ-020 SHALL move from IDLE to RST_DLY when start=1, clear done, pass, timeout and err_ch, and load the counter with RST_DLY_CYC-1.
REQ-021 SHALL advance to the next state when the counter reaches 0 in RST_DLY (to RST_ASSERT), RST_ASSERT (to WAIT_INIT) and RUN; otherwise it SHALL decrement the counter by 1 each cycle.
REQ-022 SHALL drive ddr_rstn=0 exactly while in RST_ASSERT, a low pulse of RST_LEN_CYC cycles, and ddr_rstn=1 in all other states.
REQ-023 SHALL go from WAIT_INIT to RUN, loading the counter with RUN_CYC-1, on the first cycle where init_done is all ones (AND-reduce over NUM_CH).
REQ-024 SHALL go from WAIT_INIT to FAIL with timeout=1 if the counter, loaded with INIT_TO_CYC-1, reaches 0 before that condition holds.
REQ-025 SHALL give init completion priority when init completes and the counter reaches 0 in the same cycle (no timeout).
REQ-026 SHALL, in RUN, OR err_flag into err_ch every cycle.
REQ-027 SHALL treat a drop of any init_done bit in RUN as a failure: go to FAIL next cycle, with timeout left at 0.
REQ-028 SHALL, at the end of RUN, go to PASS if err_ch plus the current-cycle err_flag equals 0, else go to FAIL.
REQ-029 SHALL set done=1 in PASS and FAIL, and set pass=1 only in PASS; both states SHALL hold until the next start, which re-enters RST_DLY.
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL treat parameter values of 0 for any *_CYC parameter as 1.
REQ-032 SHALL use a single CNT_W-bit counter, with loads truncated to CNT_W bits.

Reset
REQ-033 SHALL, on rst high, asynchronously force state=IDLE, counter=0, ddr_rstn=1, busy=0, done=0, pass=0, timeout=0 and err_ch=0.
REQ-034 SHALL, when rst asserts mid-sequence, abort immediately with no verdict, and release ddr_rstn to 1.

Configuration
REQ-035 SHALL, with DDR_SIM_SEQ_SYNC_EN defined, pass init_done and err_flag through a two-flop synchronizer per bit (reset to 0) before use, which adds 2 cycles of detection latency.
REQ-036 SHALL, with DDR_SIM_SEQ_SYNC_EN undefined, use init_done and err_flag directly, with no added latency.

Verification
REQ-037 SHALL cover: NUM_CH=4, RST_DLY=1, RST_LEN=5, start pulse -> ddr_rstn low for exactly 5 cycles starting 2 cycles after start, and busy=1.
REQ-038 SHALL cover: all init_done rise 100 cycles after reset release, RUN_CYC=50, no errors -> done=1 and pass=1, with state 5 reached 51 cycles after init is seen.
REQ-039 SHALL cover: INIT_TO_CYC=64 with init_done[2] stuck at 0 -> FAIL after 64 cycles in WAIT_INIT, with timeout=1 and pass=0.
REQ-040 SHALL cover: a one-cycle err_flag[1] pulse mid-RUN -> err_ch=4'b0010, FAIL at the end of RUN, and timeout=0.
REQ-041 SHALL cover: rst pulsed during RUN -> all outputs return to their reset values asynchronously, and a following start reruns cleanly.
REQ-042 SHALL cover: the bench compiled with DDR_SIM_SEQ_SYNC_EN -> RUN entry 2 cycles later than without it.

Source files
------------

// File: rtl/ddr_sim_sequencer.sv
// DDR simulation sequencer: reset pulse, init wait with timeout, timed traffic run, sticky verdict.
// Optional DDR_SIM_SEQ_SYNC_EN adds two-flop synchronizers on init_done and err_flag.
module ddr_sim_sequencer #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned RST_DLY_CYC = 1,
  parameter int unsigned RST_LEN_CYC = 5,
  parameter int unsigned INIT_TO_CYC = 200000,
  parameter int unsigned RUN_CYC     = 20000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] init_done,
  input  logic [NUM_CH-1:0] err_flag,
  output logic              ddr_rstn,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [NUM_CH-1:0] err_ch,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RST_DLY    = 3'd1,
    S_RST_ASSERT = 3'd2,
    S_WAIT_INIT  = 3'd3,
    S_RUN        = 3'd4,
    S_PASS       = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  // Zero-length phases behave as one cycle
  localparam int unsigned DLY_N = (RST_DLY_CYC == 0) ? 1 : RST_DLY_CYC;
  localparam int unsigned LEN_N = (RST_LEN_CYC == 0) ? 1 : RST_LEN_CYC;
  localparam int unsigned TO_N  = (INIT_TO_CYC == 0) ? 1 : INIT_TO_CYC;
  localparam int unsigned RUN_N = (RUN_CYC == 0) ? 1 : RUN_CYC;

  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DLY_N - 1);
  localparam logic [CNT_W-1:0] LEN_LD = CNT_W'(LEN_N - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(TO_N - 1);
  localparam logic [CNT_W-1:0] RUN_LD = CNT_W'(RUN_N - 1);

  state_t            st;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] init_s;
  logic [NUM_CH-1:0] err_s;
  logic              init_all;
  logic              cnt_zero;

`ifdef DDR_SIM_SEQ_SYNC_EN
  logic [NUM_CH-1:0] init_q1, init_q2;
  logic [NUM_CH-1:0] err_q1, err_q2;

  // Two-flop synchronizers for the asynchronous status inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q1 <= '0;
      init_q2 <= '0;
      err_q1  <= '0;
      err_q2  <= '0;
    end else begin
      init_q1 <= init_done;
      init_q2 <= init_q1;
      err_q1  <= err_flag;
      err_q2  <= err_q1;
    end
  end

  assign init_s = init_q2;
  assign err_s  = err_q2;
`else
  assign init_s = init_done;
  assign err_s  = err_flag;
`endif

  assign init_all = &init_s;
  assign cnt_zero = (cnt == '0);
  assign state    = st;

  // Sequencer FSM with shared down-counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      cnt      <= '0;
      ddr_rstn <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      err_ch   <= '0;
    end else begin
      case (st)
        S_IDLE, S_PASS, S_FAIL: begin
          if (start) begin
            st      <= S_RST_DLY;
            cnt     <= DLY_LD;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
            err_ch  <= '0;
          end
        end
        S_RST_DLY: begin
          if (cnt_zero) begin
            st       <= S_RST_ASSERT;
            cnt      <= LEN_LD;
            ddr_rstn <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RST_ASSERT: begin
          if (cnt_zero) begin
            st       <= S_WAIT_INIT;
            cnt      <= TO_LD;
            ddr_rstn <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT_INIT: begin
          // Init completion wins over a simultaneous timeout
          if (init_all) begin
            st  <= S_RUN;
            cnt <= RUN_LD;
          end else if (cnt_zero) begin
            st      <= S_FAIL;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RUN: begin
          err_ch <= err_ch | err_s;
          if (!init_all) begin
            st   <= S_FAIL;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (cnt_zero) begin
            busy <= 1'b0;
            done <= 1'b1;
            if ((err_ch | err_s) == '0) begin
              st   <= S_PASS;
              pass <= 1'b1;
            end else begin
              st <= S_FAIL;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          st       <= S_IDLE;
          ddr_rstn <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_sim_sequencer.sv
// Directed bench for ddr_sim_sequencer: two instances, one for the normal flow and one with a short init timeout.
module tb_ddr_sim_sequencer;

`ifdef DDR_SIM_SEQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk, rst, start_a, start_b;
  logic [3:0] init_a, init_b, err_a, err_b;
  logic       rstn_a, busy_a, done_a, pass_a, to_a;
  logic       rstn_b, busy_b, done_b, pass_b, to_b;
  logic [3:0] errch_a, errch_b;
  logic [2:0] state_a, state_b;
  int         checks = 0;
  int         failures = 0;
  int         n;

  ddr_sim_sequencer #(
    .NUM_CH(4), .RST_DLY_CYC(1), .RST_LEN_CYC(5),
    .INIT_TO_CYC(1000), .RUN_CYC(50), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .init_done(init_a), .err_flag(err_a),
    .ddr_rstn(rstn_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .timeout(to_a), .err_ch(errch_a), .state(state_a)
  );

  ddr_sim_sequencer #(
    .NUM_CH(4), .RST_DLY_CYC(1), .RST_LEN_CYC(5),
    .INIT_TO_CYC(64), .RUN_CYC(50), .CNT_W(32)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .init_done(init_b), .err_flag(err_b),
    .ddr_rstn(rstn_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .timeout(to_b), .err_ch(errch_b), .state(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a state; not reaching it is reported as a failed comparison
  task automatic wait_st(input bit sel_b, input logic [2:0] tgt, input int limit,
                         input string tag, output int cnt);
    cnt = 0;
    while (((sel_b ? state_b : state_a) !== tgt) && (cnt < limit)) begin
      tick();
      cnt++;
    end
    chk(tag, 32'(sel_b ? state_b : state_a), 32'(tgt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    init_a = 4'h0; init_b = 4'b1011; err_a = 4'h0; err_b = 4'h0;
    repeat (3) tick();

    chk("rst_state", 32'(state_a), 0);
    chk("rst_rstn", 32'(rstn_a), 1);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_timeout", 32'(to_a), 0);
    chk("rst_errch", 32'(errch_a), 0);
    chk("rst_state_b", 32'(state_b), 0);

    rst = 1'b0;
    tick();

    // Reset pulse shape
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("dly_state", 32'(state_a), 1);
    chk("dly_busy", 32'(busy_a), 1);
    chk("dly_rstn", 32'(rstn_a), 1);
    tick();
    chk("assert_state", 32'(state_a), 2);
    chk("assert_rstn", 32'(rstn_a), 0);
    n = 0;
    for (int i = 0; i < 20 && rstn_a === 1'b0; i++) begin
      n++;
      tick();
    end
    chk("rstn_low_len", 32'(n), 5);
    chk("wait_init_state", 32'(state_a), 3);

    // start while busy is ignored
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("busy_start_ignored", 32'(state_a), 3);
    chk("busy_in_wait", 32'(busy_a), 1);

    // Init arrives ~100 cycles after reset release, then a clean run
    repeat (98) tick();
    init_a = 4'hF;
    wait_st(1'b0, 3'd4, 20, "run_entry", n);
    chk("run_entry_lat", 32'(n), 32'(1 + SL));
    wait_st(1'b0, 3'd5, 100, "pass_state", n);
    chk("run_len", 32'(n), 50);
    chk("pass_done", 32'(done_a), 1);
    chk("pass_pass", 32'(pass_a), 1);
    chk("pass_busy", 32'(busy_a), 0);
    chk("pass_timeout", 32'(to_a), 0);
    chk("pass_errch", 32'(errch_a), 0);

    // Single-cycle error on channel 1 mid-run
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("restart_state", 32'(state_a), 1);
    chk("restart_done_clr", 32'(done_a), 0);
    chk("restart_pass_clr", 32'(pass_a), 0);
    wait_st(1'b0, 3'd4, 20, "run2_entry", n);
    chk("run2_entry_lat", 32'(n), 7);
    repeat (20) tick();
    err_a = 4'b0010; tick(); err_a = 4'h0;
    repeat (3) tick();
    chk("err_capture", 32'(errch_a), 32'h2);
    chk("err_still_run", 32'(state_a), 4);
    wait_st(1'b0, 3'd6, 100, "err_fail_state", n);
    chk("err_fail_at_end", 32'(n), 26);
    chk("err_done", 32'(done_a), 1);
    chk("err_pass", 32'(pass_a), 0);
    chk("err_timeout", 32'(to_a), 0);
    chk("err_errch", 32'(errch_a), 32'h2);

    // Async reset mid-run, then a clean rerun
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_st(1'b0, 3'd4, 20, "run3_entry", n);
    err_a = 4'b1000; tick(); err_a = 4'h0;
    repeat (4) tick();
    chk("pre_rst_errch", 32'(errch_a), 32'h8);
    rst = 1'b1;
    #2;
    chk("arst_state", 32'(state_a), 0);
    chk("arst_rstn", 32'(rstn_a), 1);
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_done", 32'(done_a), 0);
    chk("arst_pass", 32'(pass_a), 0);
    chk("arst_timeout", 32'(to_a), 0);
    chk("arst_errch", 32'(errch_a), 0);
    tick();
    rst = 1'b0;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_st(1'b0, 3'd5, 100, "rerun_pass_state", n);
    chk("rerun_pass", 32'(pass_a), 1);
    chk("rerun_done", 32'(done_a), 1);

    // Init timeout with init_done[2] stuck low
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_st(1'b1, 3'd3, 20, "b_wait_init", n);
    wait_st(1'b1, 3'd6, 200, "b_timeout_state", n);
    chk("b_timeout_len", 32'(n), 64);
    chk("b_timeout", 32'(to_b), 1);
    chk("b_pass", 32'(pass_b), 0);
    chk("b_done", 32'(done_b), 1);
    chk("b_busy", 32'(busy_b), 0);
    chk("b_rstn", 32'(rstn_b), 1);

    // init_done drop during run
    init_b = 4'hF;
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("b_timeout_clr", 32'(to_b), 0);
    wait_st(1'b1, 3'd4, 40, "b_run_entry", n);
    repeat (5) tick();
    init_b = 4'b1110;
    wait_st(1'b1, 3'd6, 10, "b_drop_fail", n);
    chk("b_drop_lat", 32'(n), 32'(1 + SL));
    chk("b_drop_timeout", 32'(to_b), 0);
    chk("b_drop_done", 32'(done_b), 1);
    chk("b_drop_pass", 32'(pass_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
